// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: condition-field encodings and
// the bit positions of N,Z,C,V inside the packed flag vector {N,Z,C,V}.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM-style condition field against a
// packed {N,Z,C,V} flag vector. Reserved encoding 4'hF never passes.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Flag register, conditional-execution gating of PCSrc/RegWrite/MemWrite.
// Optional saturating executed/squashed counters when COND_STATS_EN is defined.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             alu_n_i,
  input  logic             alu_z_i,
  input  logic             alu_c_i,
  input  logic             alu_v_i,
  output logic             cond_ex_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  logic [3:0] r_flags;
  logic [3:0] w_cond;
  logic       w_pass;
  logic       w_exec;

  // Idle cycles present the reserved code so an undriven cond_i cannot leak.
  assign w_cond = valid_i ? cond_i : COND_NV;

  cond_check u_cond_check (
    .i_cond  (w_cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign w_exec      = valid_i & w_pass;
  assign cond_ex_o   = w_exec;
  assign pc_src_o    = pcs_i   & w_exec;
  assign reg_write_o = reg_w_i & w_exec;
  assign mem_write_o = mem_w_i & w_exec;
  assign flags_o     = r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      if (w_exec && flag_w_i[1]) begin
        r_flags[FLAG_N] <= alu_n_i;
        r_flags[FLAG_Z] <= alu_z_i;
      end
      if (w_exec && flag_w_i[0]) begin
        r_flags[FLAG_C] <= alu_c_i;
        r_flags[FLAG_V] <= alu_v_i;
      end
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_squash_cnt;
  logic             w_squash;

  assign w_squash = valid_i & ~w_pass;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_cnt   <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_exec && (r_exec_cnt != '1)) begin
        r_exec_cnt <= r_exec_cnt + CNT_W'(1);
      end
      if (w_squash && (r_squash_cnt != '1)) begin
        r_squash_cnt <= r_squash_cnt + CNT_W'(1);
      end
    end
  end

  assign exec_cnt_o   = r_exec_cnt;
  assign squash_cnt_o = r_squash_cnt;
`else
  assign exec_cnt_o   = '0;
  assign squash_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: each applied instruction pushes its expected
// outputs, which are popped and compared once the combinational result settles.
module tb_cond_unit;

`ifdef COND_STATS_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                valid_i;
  logic [3:0]          cond_i;
  logic [1:0]          flag_w_i;
  logic                pcs_i, reg_w_i, mem_w_i;
  logic                alu_n_i, alu_z_i, alu_c_i, alu_v_i;
  logic                cond_ex_o, pc_src_o, reg_write_o, mem_write_o;
  logic [3:0]          flags_o;
  logic [TB_CNT_W-1:0] exec_cnt_o, squash_cnt_o;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .cond_i       (cond_i),
    .flag_w_i     (flag_w_i),
    .pcs_i        (pcs_i),
    .reg_w_i      (reg_w_i),
    .mem_w_i      (mem_w_i),
    .alu_n_i      (alu_n_i),
    .alu_z_i      (alu_z_i),
    .alu_c_i      (alu_c_i),
    .alu_v_i      (alu_v_i),
    .cond_ex_o    (cond_ex_o),
    .pc_src_o     (pc_src_o),
    .reg_write_o  (reg_write_o),
    .mem_write_o  (mem_write_o),
    .flags_o      (flags_o),
    .exec_cnt_o   (exec_cnt_o),
    .squash_cnt_o (squash_cnt_o)
  );

  typedef struct packed {
    logic [3:0]          strobes;  // {cond_ex, pc_src, reg_write, mem_write}
    logic [3:0]          flags;
    logic [TB_CNT_W-1:0] exec;
    logic [TB_CNT_W-1:0] squash;
  } exp_t;

  exp_t                sb_q[$];
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [3:0]          m_flags;
  logic [TB_CNT_W-1:0] m_exec, m_squash;

  // Truth vector indexed by condition code, bit 15 = reserved, bit 0 = EQ.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic [15:0] t;
    {n, z, cy, v} = f;
    t = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v),
         n ^ v, ~(n ^ v), ~cy | z, cy & ~z,
         ~v, v, ~n, n, ~cy, cy, ~z, z};
    return t[c];
  endfunction

  task automatic apply(input logic rst, input logic v, input logic [3:0] c,
                       input logic [1:0] fw, input logic [2:0] strb,
                       input logic [3:0] nzcv);
    exp_t e, got;
    logic pass;
    @(negedge clk);
    reset = rst; valid_i = v; cond_i = c; flag_w_i = fw;
    {pcs_i, reg_w_i, mem_w_i} = strb;
    {alu_n_i, alu_z_i, alu_c_i, alu_v_i} = nzcv;
    pass = (v === 1'b1) ? cond_model(c, m_flags) : 1'b0;
    e.strobes = {pass, strb[2] & pass, strb[1] & pass, strb[0] & pass};
    e.flags   = m_flags;
    e.exec    = m_exec;
    e.squash  = m_squash;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    got = {cond_ex_o, pc_src_o, reg_write_o, mem_write_o, flags_o, exec_cnt_o, squash_cnt_o};
    n_vec++;
    if (got.strobes !== e.strobes) begin
      n_err++;
      $display("FAIL strobes cond=%h: got %b expected %b", c, got.strobes, e.strobes);
    end
    n_vec++;
    if (got.flags !== e.flags) begin
      n_err++;
      $display("FAIL flags: got %b expected %b", got.flags, e.flags);
    end
    n_vec++;
    if (got.exec !== e.exec) begin
      n_err++;
      $display("FAIL exec_cnt: got %0d expected %0d", got.exec, e.exec);
    end
    n_vec++;
    if (got.squash !== e.squash) begin
      n_err++;
      $display("FAIL squash_cnt: got %0d expected %0d", got.squash, e.squash);
    end
    if (rst) begin
      m_flags = '0; m_exec = '0; m_squash = '0;
    end else if (v === 1'b1) begin
      if (pass && fw[1]) m_flags[3:2] = nzcv[3:2];
      if (pass && fw[0]) m_flags[1:0] = nzcv[1:0];
`ifdef COND_STATS_EN
      if (pass && m_exec != '1) m_exec++;
      if (!pass && m_squash != '1) m_squash++;
`endif
    end
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 4'hE, 2'b11, 3'b111, 4'b1111);
    apply(1'b1, 1'b1, 4'hE, 2'b11, 3'b111, 4'b1111);
    @(posedge clk); #1;
    n_vec++;
    if (flags_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", flags_o);
    end
  endtask

  task automatic test_basic();
    apply(1'b0, 1'b1, 4'hE, 2'b11, 3'b010, 4'b0100);
    @(posedge clk); #1;
    n_vec++;
    if (flags_o !== 4'b0100) begin
      n_err++;
      $display("FAIL first_write: got %b expected 0100", flags_o);
    end
    apply(1'b0, 1'b1, 4'h0, 2'b00, 3'b100, 4'b0000);
    apply(1'b0, 1'b1, 4'h1, 2'b00, 3'b100, 4'b0000);
    apply(1'b0, 1'b1, 4'h1, 2'b11, 3'b111, 4'b1000);
    @(posedge clk); #1;
    n_vec++;
    if (flags_o !== 4'b0100) begin
      n_err++;
      $display("FAIL squash_hold: got %b expected 0100", flags_o);
    end
  endtask

  task automatic test_partial_write();
    apply(1'b0, 1'b1, 4'hE, 2'b11, 3'b000, 4'b0010);
    apply(1'b0, 1'b1, 4'hE, 2'b10, 3'b000, 4'b1011);
    @(posedge clk); #1;
    n_vec++;
    if (flags_o !== 4'b1010) begin
      n_err++;
      $display("FAIL nz_only_write: got %b expected 1010", flags_o);
    end
    apply(1'b0, 1'b1, 4'hA, 2'b00, 3'b111, 4'b0000);
    apply(1'b0, 1'b1, 4'hB, 2'b00, 3'b111, 4'b0000);
    apply(1'b0, 1'b1, 4'hE, 2'b01, 3'b000, 4'b0101);
  endtask

  task automatic test_reserved_and_idle();
    apply(1'b0, 1'b1, 4'hF, 2'b11, 3'b111, 4'b1111);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 4'bxxxx, 2'b11, 3'b111, 4'b1111);
    apply(1'b0, 1'b0, 4'hE, 2'b11, 3'b111, 4'b0000);
    apply(1'b1, 1'b1, 4'hE, 2'b11, 3'b111, 4'b1111);
    @(posedge clk); #1;
    n_vec++;
    if (flags_o !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_dominant: got %b expected 0000", flags_o);
    end
  endtask

  task automatic test_table();
    for (int f = 0; f < 16; f++) begin
      apply(1'b0, 1'b1, 4'hE, 2'b11, 3'b000, 4'(f));
      for (int c = 0; c < 16; c++) apply(1'b0, 1'b1, 4'(c), 2'b00, 3'b111, 4'b0000);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 4'hE, 2'b11, 3'b000, 4'b0100);
    apply(1'b0, 1'b1, 4'h0, 2'b11, 3'b010, 4'b0000);
    apply(1'b0, 1'b1, 4'h0, 2'b11, 3'b010, 4'b1000);
    apply(1'b0, 1'b1, 4'h1, 2'b11, 3'b010, 4'b0001);
    apply(1'b0, 1'b1, 4'hB, 2'b01, 3'b001, 4'b0000);
  endtask

  task automatic test_counters();
    apply(1'b1, 1'b0, 4'h0, 2'b00, 3'b000, 4'b0000);
    for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 4'hE, 2'b00, 3'b010, 4'b0000);
    for (int i = 0; i < 3; i++)  apply(1'b0, 1'b1, 4'hF, 2'b00, 3'b010, 4'b0000);
    for (int i = 0; i < 4; i++)  apply(1'b0, 1'b0, 4'hE, 2'b11, 3'b111, 4'b0000);
    @(posedge clk); #1;
`ifdef COND_STATS_EN
    n_vec++;
    if (exec_cnt_o !== 4'hF) begin
      n_err++;
      $display("FAIL exec_saturate: got %h expected f", exec_cnt_o);
    end
    n_vec++;
    if (squash_cnt_o !== 4'd3) begin
      n_err++;
      $display("FAIL squash_count: got %0d expected 3", squash_cnt_o);
    end
`else
    n_vec++;
    if ({exec_cnt_o, squash_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL counters_tied: got %h/%h expected 0/0", exec_cnt_o, squash_cnt_o);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; cond_i = 4'h0; flag_w_i = 2'b00;
    pcs_i = 1'b0; reg_w_i = 1'b0; mem_w_i = 1'b0;
    alu_n_i = 1'b0; alu_z_i = 1'b0; alu_c_i = 1'b0; alu_v_i = 1'b0;
    m_flags = '0; m_exec = '0; m_squash = '0;
    test_reset();
    test_basic();
    test_partial_write();
    test_reserved_and_idle();
    test_table();
    test_back_to_back();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
